proj_stream_unit: RTL and testbench

- Next-generation Q/K/V projection engine: streams the hidden vector in LANES-wide chunks instead of taking all N elements at once.
- Accumulates NPROJ×PE_NUM dot products over N/LANES input beats, then holds the full result set behind a valid/ready output handshake.
- Sits between the embedding/layernorm stream and the attention score stage.
- Generalises the projection count (NPROJ) and the input parallelism (LANES), and adds backpressure and abort/restart.

---
 rtl/proj_pkg.sv | 31 +++
 rtl/proj_dot_lane.sv | 34 +++
 rtl/proj_stream_unit.sv | 144 ++++++++++++++
 tb/tb_proj_stream_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared types and helpers for the streaming Q/K/V projection engine.
// round_sat is used only when PROJ_REQUANT_EN is defined.
package proj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } proj_state_e;

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  // Round half up by adding 1<<(shift-1), arithmetic shift, then clamp to a signed ow-bit range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                   input int shift,
                                                   input int ow);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = v;
    if (shift > 0) r = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/proj_dot_lane.sv
// Combinational LANES-wide signed dot product; products are sign-extended to AW before summing.
module proj_dot_lane #(
  parameter int DW    = 4,
  parameter int LANES = 16,
  parameter int AW    = 18
) (
  input  logic [LANES*DW-1:0] x,
  input  logic [LANES*DW-1:0] w,
  output logic [AW-1:0]       dot
);

  logic signed [AW-1:0] prod_ext [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic signed [DW-1:0]   xa;
      logic signed [DW-1:0]   wa;
      logic signed [2*DW-1:0] p;
      xa = x[l*DW +: DW];
      wa = w[l*DW +: DW];
      p  = xa * wa;
      prod_ext[l] = {{(AW - 2*DW){p[2*DW-1]}}, p};
    end
  end

  // Plain reduction; synthesis rebalances it into a tree.
  always_comb begin
    logic signed [AW-1:0] sum;
    sum = '0;
    for (int l = 0; l < LANES; l++) sum = sum + prod_ext[l];
    dot = sum;
  end

endmodule

// File: rtl/proj_stream_unit.sv
// Streaming NPROJ x PE_NUM projection engine with valid/ready in and out, abort/restart on start.
// Optional macro PROJ_REQUANT_EN: round/shift/saturate results to 2*DW bits.
module proj_stream_unit
  import proj_pkg::*;
#(
  parameter int N      = 768,
  parameter int DW     = 4,
  parameter int PE_NUM = 12,
  parameter int NPROJ  = 3,
  parameter int LANES  = 16,
  parameter int SHIFT  = 4,
  localparam int AW    = acc_width(DW, N),
`ifdef PROJ_REQUANT_EN
  localparam int OW    = 2 * DW,
`else
  localparam int OW    = AW,
`endif
  localparam int NOUT  = NPROJ * PE_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DW-1:0]      in_vec,
  input  logic [NOUT*LANES*DW-1:0] w_chunk,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NOUT*OW-1:0]       out_acc,
  output logic                     busy
);

  localparam int BEATS = N / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((N % LANES) != 0 || SHIFT < 0) begin : g_param_check
    $error("proj_stream_unit: N must be a multiple of LANES and SHIFT non-negative");
  end

  proj_state_e          state_q, state_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [AW-1:0] acc_q [NOUT];
  logic signed [AW-1:0] acc_d [NOUT];
  logic signed [OW-1:0] out_acc_q [NOUT];
  logic signed [OW-1:0] out_acc_d [NOUT];
  logic signed [AW-1:0] dot [NOUT];
  logic signed [AW-1:0] sum_nxt [NOUT];

  for (genvar i = 0; i < NOUT; i++) begin : g_lane
    proj_dot_lane #(
      .DW    (DW),
      .LANES (LANES),
      .AW    (AW)
    ) u_dot (
      .x   (in_vec),
      .w   (w_chunk[i*LANES*DW +: LANES*DW]),
      .dot (dot[i])
    );
    assign out_acc[i*OW +: OW] = out_acc_q[i];
  end

  always_comb begin
    for (int i = 0; i < NOUT; i++) sum_nxt[i] = acc_q[i] + dot[i];
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    out_acc_d   = out_acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACCUM;
          beat_cnt_d = '0;
          for (int i = 0; i < NOUT; i++) acc_d[i] = '0;
        end
      end
      ACCUM: begin
        if (start) begin
          // Abort: a beat presented alongside start is dropped on purpose.
          beat_cnt_d = '0;
          for (int i = 0; i < NOUT; i++) acc_d[i] = '0;
        end else if (in_valid) begin
          acc_d      = sum_nxt;
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q == CW'(BEATS - 1)) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            for (int i = 0; i < NOUT; i++) begin
`ifdef PROJ_REQUANT_EN
              out_acc_d[i] = OW'(round_sat(64'(sum_nxt[i]), SHIFT, OW));
`else
              out_acc_d[i] = sum_nxt[i];
`endif
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d    = ACCUM;
            beat_cnt_d = '0;
            for (int i = 0; i < NOUT; i++) acc_d[i] = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NOUT; i++) begin
        acc_q[i]     <= '0;
        out_acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      out_acc_q   <= out_acc_d;
    end
  end

endmodule

// File: tb/tb_proj_stream_unit.sv
// Directed bench for proj_stream_unit (N=8, LANES=4, PE_NUM=2, NPROJ=3, DW=4).
module tb_proj_stream_unit;

  localparam int N      = 8;
  localparam int DW     = 4;
  localparam int PE_NUM = 2;
  localparam int NPROJ  = 3;
  localparam int LANES  = 4;
  localparam int SHIFT  = 4;
  localparam int AW     = 2 * DW + $clog2(N);
`ifdef PROJ_REQUANT_EN
  localparam int OW     = 2 * DW;
`else
  localparam int OW     = AW;
`endif
  localparam int NOUT   = NPROJ * PE_NUM;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*DW-1:0]      in_vec;
  logic [NOUT*LANES*DW-1:0] w_chunk;
  logic                     out_valid;
  logic                     out_ready;
  logic [NOUT*OW-1:0]       out_acc;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  proj_stream_unit #(
    .N(N), .DW(DW), .PE_NUM(PE_NUM), .NPROJ(NPROJ), .LANES(LANES), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .w_chunk(w_chunk), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int get_acc(input int i);
    logic signed [OW-1:0] t;
    t = out_acc[i*OW +: OW];
    return int'(t);
  endfunction

  // Expected visible value for a raw dot-product sum.
  function automatic int exp_val(input int raw);
`ifdef PROJ_REQUANT_EN
    int r;
    r = (raw + (1 << (SHIFT - 1))) >>> SHIFT;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
`else
    return raw;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int x, input int w);
    for (int l = 0; l < LANES; l++) in_vec[l*DW +: DW] = x[DW-1:0];
    for (int k = 0; k < NOUT * LANES; k++) w_chunk[k*DW +: DW] = w[DW-1:0];
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beats2(input int x, input int w);
    set_data(x, w);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_data(0, 0);
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (out_acc !== '0) begin bad++; $display("FAIL reset_out_acc got %h want 0", out_acc); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    pulse_start();
    total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_accum ready=%b busy=%b want 1 1", in_ready, busy); end
    set_data(1, 1);
    in_valid = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got %b want 1", out_valid); end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (get_acc(i) !== exp_val(8)) begin bad++; $display("FAIL basic_acc[%0d] got %0d want %0d", i, get_acc(i), exp_val(8)); end
    end
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_release valid=%b busy=%b want 0 0", out_valid, busy); end
    total++; if (get_acc(0) !== exp_val(8)) begin bad++; $display("FAIL basic_keep got %0d want %0d", get_acc(0), exp_val(8)); end
  endtask

  task automatic test_extremes;
    out_ready = 1'b1;
    pulse_start();
    beats2(-8, -8);
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (get_acc(i) !== exp_val(512)) begin bad++; $display("FAIL max_pos[%0d] got %0d want %0d", i, get_acc(i), exp_val(512)); end
    end
    tick();
    pulse_start();
    beats2(7, -8);
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (get_acc(i) !== exp_val(-448)) begin bad++; $display("FAIL max_neg[%0d] got %0d want %0d", i, get_acc(i), exp_val(-448)); end
    end
    tick();
  endtask

  task automatic test_mixed;
    // Row index k gets weight k-3; lane l gets x=l+1, so each row sums 2*10*(k-3).
    out_ready = 1'b1;
    pulse_start();
    for (int l = 0; l < LANES; l++) in_vec[l*DW +: DW] = DW'(l + 1);
    for (int k = 0; k < NOUT; k++)
      for (int l = 0; l < LANES; l++) w_chunk[(k*LANES+l)*DW +: DW] = DW'(k - 3);
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    for (int k = 0; k < NOUT; k++) begin
      total++;
      if (get_acc(k) !== exp_val(20 * (k - 3))) begin bad++; $display("FAIL mixed[%0d] got %0d want %0d", k, get_acc(k), exp_val(20 * (k - 3))); end
    end
    tick();
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    pulse_start();
    beats2(3, 1);
    set_data(5, 5);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL hold_flags[%0d] valid=%b ready=%b want 1 0", c, out_valid, in_ready); end
      total++;
      if (get_acc(4) !== exp_val(24)) begin bad++; $display("FAIL hold_stable[%0d] got %0d want %0d", c, get_acc(4), exp_val(24)); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_release valid=%b busy=%b want 0 0", out_valid, busy); end
    total++; if (get_acc(5) !== exp_val(24)) begin bad++; $display("FAIL hold_keep got %0d want %0d", get_acc(5), exp_val(24)); end
  endtask

  task automatic test_abort;
    out_ready = 1'b1;
    pulse_start();
    set_data(1, 1);
    in_valid = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL abort_state ready=%b valid=%b want 1 0", in_ready, out_valid); end
    set_data(2, 1);
    tick(); tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL abort_valid got %b want 1", out_valid); end
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (get_acc(i) !== exp_val(16)) begin bad++; $display("FAIL abort_acc[%0d] got %0d want %0d", i, get_acc(i), exp_val(16)); end
    end
    tick();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    pulse_start();
    beats2(1, 1);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_state valid=%b busy=%b ready=%b want 0 1 1", out_valid, busy, in_ready); end
    beats2(3, 1);
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (get_acc(i) !== exp_val(24)) begin bad++; $display("FAIL b2b_acc[%0d] got %0d want %0d", i, get_acc(i), exp_val(24)); end
    end
    tick();
  endtask

  task automatic test_idle_start_valid;
    out_ready = 1'b1;
    set_data(5, 1);
    in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_data(1, 1);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_beat_taken valid=%b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    total++; if (get_acc(2) !== exp_val(8) || out_valid !== 1'b1) begin bad++; $display("FAIL idle_start_acc got %0d valid=%b want %0d 1", get_acc(2), out_valid, exp_val(8)); end
    tick();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    pulse_start();
    set_data(2, 2);
    in_valid = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_flags ready=%b busy=%b valid=%b want 0 0 0", in_ready, busy, out_valid); end
    total++; if (out_acc !== '0) begin bad++; $display("FAIL arst_acc got %h want 0", out_acc); end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    beats2(1, 1);
    for (int i = 0; i < NOUT; i++) begin
      total++;
      if (get_acc(i) !== exp_val(8)) begin bad++; $display("FAIL arst_rerun[%0d] got %0d want %0d", i, get_acc(i), exp_val(8)); end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_mixed();
    test_hold();
    test_abort();
    test_back_to_back();
    test_idle_start_valid();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
